// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multi-cycle controller: opcodes, functs, ALU codes, states.
// MIPS_CTRL_MOVZ_EN makes funct 001010 (movz) a legal R-type instruction.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_MOVZ = 6'b001010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [10:0] ALU_F_NONE = 11'h000;
  localparam logic [10:0] ALU_F_ADD  = 11'h020;
  localparam logic [10:0] ALU_F_SUB  = 11'h022;
  localparam logic [10:0] ALU_F_AND  = 11'h024;
  localparam logic [10:0] ALU_F_OR   = 11'h025;
  localparam logic [10:0] ALU_F_XOR  = 11'h026;
  localparam logic [10:0] ALU_F_SLT  = 11'h02A;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

  localparam logic [2:0] CLS_ALU  = 3'd0;
  localparam logic [2:0] CLS_LW   = 3'd1;
  localparam logic [2:0] CLS_SW   = 3'd2;
  localparam logic [2:0] CLS_BEQ  = 3'd3;
  localparam logic [2:0] CLS_J    = 3'd4;
  localparam logic [2:0] CLS_MOVZ = 3'd5;
  localparam logic [2:0] CLS_ILL  = 3'd7;

  // Only sll may carry a nonzero shamt; every other funct needs shamt == 0.
  function automatic logic rtype_legal(input logic [5:0] fn, input logic [4:0] sh);
    logic ok;
    ok = 1'b0;
    case (fn)
      FN_SLL: ok = 1'b1;
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT: ok = (sh == 5'd0);
`ifdef MIPS_CTRL_MOVZ_EN
      FN_MOVZ: ok = (sh == 5'd0);
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_ctrl_dec.sv
// Combinational instruction decoder: instruction word -> ALU function, legality, class, write address.
// MIPS_CTRL_MOVZ_EN (via mips_pkg) enables the movz class.
module mips_ctrl_dec
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [10:0] alu_f,
  output logic        legal,
  output logic [2:0]  cls,
  output logic [4:0]  waddr,
  output logic        src_imm
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] sh;
  logic       unused_rs;

  assign op        = instr[31:26];
  assign fn        = instr[5:0];
  assign sh        = instr[10:6];
  assign unused_rs = ^instr[25:21];

  always_comb begin
    alu_f   = ALU_F_NONE;
    legal   = 1'b0;
    cls     = CLS_ILL;
    waddr   = instr[20:16];
    src_imm = 1'b0;
    case (op)
      OP_RTYPE: begin
        waddr = instr[15:11];
        if (rtype_legal(fn, sh)) begin
          legal = 1'b1;
          alu_f = instr[10:0];
          cls   = (fn == FN_MOVZ) ? CLS_MOVZ : CLS_ALU;
        end
      end
      OP_ADDI: begin legal = 1'b1; alu_f = ALU_F_ADD; cls = CLS_ALU; src_imm = 1'b1; end
      OP_LW:   begin legal = 1'b1; alu_f = ALU_F_ADD; cls = CLS_LW;  src_imm = 1'b1; end
      OP_SW:   begin legal = 1'b1; alu_f = ALU_F_ADD; cls = CLS_SW;  src_imm = 1'b1; end
      OP_BEQ:  begin legal = 1'b1; alu_f = ALU_F_SUB; cls = CLS_BEQ; end
      OP_ANDI: begin legal = 1'b1; alu_f = ALU_F_AND; cls = CLS_ALU; src_imm = 1'b1; end
      OP_ORI:  begin legal = 1'b1; alu_f = ALU_F_OR;  cls = CLS_ALU; src_imm = 1'b1; end
      OP_XORI: begin legal = 1'b1; alu_f = ALU_F_XOR; cls = CLS_ALU; src_imm = 1'b1; end
      OP_SLTI: begin legal = 1'b1; alu_f = ALU_F_SLT; cls = CLS_ALU; src_imm = 1'b1; end
      OP_J:    begin legal = 1'b1; cls = CLS_J; waddr = 5'd0; end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS control FSM (IDLE/DECODE/EXEC/MEM/WB) with MEM_LAT-cycle memory stage.
// MIPS_CTRL_MOVZ_EN adds movz: write-back only when ALU operand b is zero.
module mips_ctrl_fsm
  import mips_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        b_zero,
  output logic [10:0] alu_f,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic        mem_re,
  output logic        mem_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  logic [3:0]  cnt_q, cnt_d;

  logic [10:0] dec_alu_f;
  logic        dec_legal;
  logic [2:0]  dec_cls;
  logic [4:0]  dec_waddr;
  logic        dec_src_imm;
  logic        active;

  mips_ctrl_dec u_dec (
    .instr   (instr_q),
    .alu_f   (dec_alu_f),
    .legal   (dec_legal),
    .cls     (dec_cls),
    .waddr   (dec_waddr),
    .src_imm (dec_src_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= 32'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (instr_valid && instr_ready) instr_q <= instr;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    instr_ready = 1'b0;
    reg_we      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    illegal     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (!dec_legal) begin
          illegal = 1'b1;
          state_d = ST_IDLE;
        end else if (dec_cls == CLS_J) begin
          pc_we   = 1'b1;
          pc_sel  = PC_SEL_JUMP;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = 4'd0;
        case (dec_cls)
          CLS_LW, CLS_SW: state_d = ST_MEM;
          CLS_BEQ: begin
            pc_we   = 1'b1;
            pc_sel  = alu_zero ? PC_SEL_BRANCH : PC_SEL_SEQ;
            state_d = ST_IDLE;
          end
`ifdef MIPS_CTRL_MOVZ_EN
          CLS_MOVZ: begin
            if (b_zero) begin
              state_d = ST_WB;
            end else begin
              pc_we   = 1'b1;
              state_d = ST_IDLE;
            end
          end
`endif
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_re = (dec_cls == CLS_LW);
        mem_we = (dec_cls == CLS_SW);
        if (cnt_q == CNT_LAST) begin
          if (dec_cls == CLS_LW) begin
            state_d = ST_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WB: begin
        // Writes to $0 are discarded but the instruction still retires.
        reg_we  = (dec_waddr != 5'd0);
        pc_we   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifndef MIPS_CTRL_MOVZ_EN
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
`endif

  assign active      = (state_q != ST_IDLE);
  assign alu_f       = active ? dec_alu_f : ALU_F_NONE;
  assign alu_src_imm = active & dec_src_imm;
  assign reg_waddr   = active ? dec_waddr : 5'd0;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed self-checking bench for mips_ctrl_fsm (MEM_LAT=3); movz expectations follow MIPS_CTRL_MOVZ_EN.
module tb_mips_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        alu_zero;
  logic        b_zero;
  logic [10:0] alu_f;
  logic        alu_src_imm;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic        mem_re;
  logic        mem_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        illegal;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_ctrl_fsm #(.MEM_LAT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_zero    (alu_zero),
    .b_zero      (b_zero),
    .alu_f       (alu_f),
    .alu_src_imm (alu_src_imm),
    .reg_we      (reg_we),
    .reg_waddr   (reg_waddr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .illegal     (illegal),
    .state       (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from IDLE and tally every strobe until the FSM is back in IDLE.
  // exp_cyc counts clock edges from the accept edge until state reads IDLE again.
  task automatic run_txn(input string tag, input logic [31:0] ins, input logic az, input logic bz,
                         input int exp_cyc, input logic [10:0] exp_f, input logic exp_imm,
                         input int exp_we, input logic [4:0] exp_wa, input int exp_re,
                         input int exp_mw, input int exp_pc, input logic [1:0] exp_sel,
                         input int exp_ill);
    int cyc = 0, n_we = 0, n_re = 0, n_mw = 0, n_pc = 0, n_ill = 0;
    logic [4:0]  wa = 5'd0;
    logic [1:0]  sel = 2'd0;
    logic [10:0] f_dec = 11'h7FF, f_last = 11'h7FF;
    logic        imm_dec = 1'b0;
    check_eq({tag, ":ready"}, {31'd0, instr_ready}, 32'd1);
    alu_zero = az; b_zero = bz; instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 32'd0;
    while (state != 3'd0 && cyc < 40) begin
      if (state == 3'd1) begin f_dec = alu_f; imm_dec = alu_src_imm; end
      f_last = alu_f;
      if (reg_we) begin n_we++; wa = reg_waddr; end
      if (mem_re) n_re++;
      if (mem_we) n_mw++;
      if (illegal) n_ill++;
      if (pc_we) begin n_pc++; sel = pc_sel; end
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, ":cycles"}, cyc, exp_cyc);
    check_eq({tag, ":alu_f_dec"}, {21'd0, f_dec}, {21'd0, exp_f});
    check_eq({tag, ":alu_f_held"}, {21'd0, f_last}, {21'd0, exp_f});
    check_eq({tag, ":src_imm"}, {31'd0, imm_dec}, {31'd0, exp_imm});
    check_eq({tag, ":reg_we"}, n_we, exp_we);
    check_eq({tag, ":waddr"}, {27'd0, wa}, {27'd0, exp_wa});
    check_eq({tag, ":mem_re"}, n_re, exp_re);
    check_eq({tag, ":mem_we"}, n_mw, exp_mw);
    check_eq({tag, ":pc_we"}, n_pc, exp_pc);
    check_eq({tag, ":pc_sel"}, {30'd0, sel}, {30'd0, exp_sel});
    check_eq({tag, ":illegal"}, n_ill, exp_ill);
    $display("TXN %-10s instr=%08h cycles=%0d reg_we=%0d waddr=%0d mem_re=%0d mem_we=%0d pc_we=%0d ill=%0d",
             tag, ins, cyc, n_we, wa, n_re, n_mw, n_pc, n_ill);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0; alu_zero = 1'b0; b_zero = 1'b0;
    #12;
    check_eq("rst:state",   {29'd0, state}, 32'd0);
    check_eq("rst:alu_f",   {21'd0, alu_f}, 32'd0);
    check_eq("rst:strobes", {26'd0, reg_we, mem_re, mem_we, pc_we, illegal, alu_src_imm}, 32'd0);
    check_eq("rst:pc_sel",  {30'd0, pc_sel}, 32'd0);
    check_eq("rst:waddr",   {27'd0, reg_waddr}, 32'd0);
    $display("TXN reset     state=%0d alu_f=%0h", state, alu_f);
    #11 rst_n = 1'b1;  // released 2ns before the edge at 25ns; first accept is on that edge

    //       tag          instr         az    bz    cyc f        imm   we wa    re mw pc sel   ill
    run_txn("add",       32'h00221820, 1'b0, 1'b0, 3, 11'h020, 1'b0, 1, 5'd3, 0, 0, 1, 2'd0, 0);
    run_txn("lw",        32'h8C850008, 1'b0, 1'b0, 6, 11'h020, 1'b1, 1, 5'd5, 3, 0, 1, 2'd0, 0);
    run_txn("sw",        32'hAC850008, 1'b0, 1'b0, 5, 11'h020, 1'b1, 0, 5'd0, 0, 3, 1, 2'd0, 0);
    run_txn("beq_taken", 32'h10220004, 1'b1, 1'b0, 2, 11'h022, 1'b0, 0, 5'd0, 0, 0, 1, 2'd1, 0);
    run_txn("beq_not",   32'h10220004, 1'b0, 1'b0, 2, 11'h022, 1'b0, 0, 5'd0, 0, 0, 1, 2'd0, 0);
    run_txn("j",         32'h08000010, 1'b0, 1'b0, 1, 11'h000, 1'b0, 0, 5'd0, 0, 0, 1, 2'd2, 0);
    run_txn("ill_op",    32'hFC000000, 1'b0, 1'b0, 1, 11'h000, 1'b0, 0, 5'd0, 0, 0, 0, 2'd0, 1);
    run_txn("andi",      32'h30C700FF, 1'b0, 1'b0, 3, 11'h024, 1'b1, 1, 5'd7, 0, 0, 1, 2'd0, 0);
    run_txn("ori",       32'h34C700FF, 1'b0, 1'b0, 3, 11'h025, 1'b1, 1, 5'd7, 0, 0, 1, 2'd0, 0);
    run_txn("xori",      32'h38C700FF, 1'b0, 1'b0, 3, 11'h026, 1'b1, 1, 5'd7, 0, 0, 1, 2'd0, 0);
    run_txn("slti",      32'h28C700FF, 1'b0, 1'b0, 3, 11'h02A, 1'b1, 1, 5'd7, 0, 0, 1, 2'd0, 0);
    run_txn("addi_r0",   32'h20C00005, 1'b0, 1'b0, 3, 11'h020, 1'b1, 0, 5'd0, 0, 0, 1, 2'd0, 0);
    run_txn("sll",       32'h000220C0, 1'b0, 1'b0, 3, 11'h0C0, 1'b0, 1, 5'd4, 0, 0, 1, 2'd0, 0);
    run_txn("add_shamt", 32'h00221860, 1'b0, 1'b0, 1, 11'h000, 1'b0, 0, 5'd0, 0, 0, 0, 2'd0, 1);
    run_txn("addu_ill",  32'h00221821, 1'b0, 1'b0, 1, 11'h000, 1'b0, 0, 5'd0, 0, 0, 0, 2'd0, 1);
`ifdef MIPS_CTRL_MOVZ_EN
    run_txn("movz_b0",   32'h0023100A, 1'b0, 1'b0, 2, 11'h00A, 1'b0, 0, 5'd0, 0, 0, 1, 2'd0, 0);
    run_txn("movz_b1",   32'h0023100A, 1'b0, 1'b1, 3, 11'h00A, 1'b0, 1, 5'd2, 0, 0, 1, 2'd0, 0);
`else
    run_txn("movz_ill",  32'h0023100A, 1'b0, 1'b1, 1, 11'h000, 1'b0, 0, 5'd0, 0, 0, 0, 2'd0, 1);
`endif

    // Reset while a sw sits in its second MEM cycle.
    check_eq("rstmem:ready", {31'd0, instr_ready}, 32'd1);
    instr = 32'hAC850008; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 32'd0;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("rstmem:in_mem", {29'd0, state}, 32'd3);
    check_eq("rstmem:mem_we_before", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rstmem:mem_we_after", {31'd0, mem_we}, 32'd0);
    check_eq("rstmem:state", {29'd0, state}, 32'd0);
    check_eq("rstmem:pc_we", {31'd0, pc_we}, 32'd0);
    #2 rst_n = 1'b1;
    #0;
    check_eq("rstmem:ready_after", {31'd0, instr_ready}, 32'd1);
    $display("TXN rst_mid_mem state=%0d instr_ready=%0d", state, instr_ready);
    run_txn("add_post",  32'h00221820, 1'b0, 1'b0, 3, 11'h020, 1'b0, 1, 5'd3, 0, 0, 1, 2'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_ctrl_fsm.md
MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

Interface
REQ-001 SHALL have parameter: MEM_LAT, 1, memory-stage wait cycles for lw/sw (1..15).
REQ-002 SHALL have ports, one clock, reset asynchronous active-low:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- instr_valid  in  1  fetch offers instruction
- instr_ready  out  1  controller can accept
- instr  in  32  MIPS instruction word
- alu_zero  in  1  ALU result == 0, sampled in EXEC
- b_zero  in  1  ALU operand b == 0, sampled in EXEC
- alu_f  out  11  ALU function code {shamt[4:0], funct[5:0]}
- alu_src_imm  out  1  ALU b = sign-extended imm16
- reg_we  out  1  register-file write strobe
- reg_waddr  out  5  write address
- mem_re  out  1  data-memory read
- mem_we  out  1  data-memory write
- pc_we  out  1  PC load strobe
- pc_sel  out  2  0 = +4, 1 = branch, 2 = jump
- illegal  out  1  one-cycle illegal-instruction pulse
- state  out  3  current FSM state code

Function
REQ-003 SHALL implement states IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4; other codes go to IDLE.
REQ-004 instr_ready SHALL be 1 only in IDLE; on instr_valid & instr_ready, instr SHALL be latched and FSM SHALL go to DECODE.
REQ-005 DECODE SHALL map opcode to alu_f, held constant through EXEC/MEM/WB:
- R-type (op 000000): alu_f = instr[10:0]
- addi 001000, lw 100011, sw 101011: 00000100000
- beq 000100: 00000100010
- andi 001100: 00000100100; ori 001101: 00000100101; xori 001110: 00000100110
- slti 001010: 00000101010
REQ-006 Legal R-type funct SHALL be 100000, 100010, 100100, 100101, 100110, 101010, 000000 (sll, shamt any), and 001010 per REQ-015; shamt SHALL be 0 for non-shift funct, else illegal.
REQ-007 Illegal opcode/funct SHALL pulse illegal in DECODE, assert no strobes, return to IDLE.
REQ-008 j (000010) SHALL in DECODE assert pc_we=1, pc_sel=2 for one cycle, then IDLE.
REQ-009 alu_src_imm SHALL be 1 for I-type and lw/sw, 0 for R-type and beq.
REQ-010 EXEC (1 cycle): R-type/I-type ALU -> WB; lw/sw -> MEM; beq -> IDLE with pc_we=1, pc_sel=1 if alu_zero else pc_sel=0.
REQ-011 MEM SHALL last exactly MEM_LAT cycles with mem_re (lw) or mem_we (sw) held high; lw -> WB, sw -> IDLE.
REQ-012 WB SHALL pulse reg_we one cycle; reg_waddr = rd for R-type, rt otherwise; waddr 0 SHALL suppress reg_we.
REQ-013 Every retired non-jump, non-branch instruction SHALL pulse pc_we with pc_sel=0 in its final state.
REQ-014 Latency accept->return-to-IDLE: ALU 4, lw 4+MEM_LAT, sw 3+MEM_LAT, beq 3, j 2, illegal 2 cycles.

Reset
REQ-016 rst_n low SHALL immediately force state=IDLE and all strobes, illegal, alu_f, pc_sel, reg_waddr to 0, alu_src_imm to 0; reset mid-MEM SHALL drop mem_re/mem_we without completing.
REQ-017 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-015 Macro MIPS_CTRL_MOVZ_EN: defined -> funct 001010 legal, EXEC goes to WB only if b_zero else IDLE (pc_we, pc_sel=0 still pulsed); undefined -> funct 001010 illegal per REQ-007.

Structure
REQ-018 Shared package mips_pkg SHALL hold opcode/funct constants, alu_f codes, state encoding, pc_sel codes.
REQ-019 Decode SHALL be sub-module mips_ctrl_dec (combinational instr -> alu_f, legal, class, waddr); FSM and counter stay in mips_ctrl_fsm.

Verification
REQ-020 add $3,$1,$2 (0x00221820) -> alu_f=0x020, reg_we pulse with waddr=3 in WB, back in IDLE 4 cycles after accept.
REQ-021 lw $5,8($4), MEM_LAT=3 -> alu_f=0x020, alu_src_imm=1, mem_re high 3 cycles, reg_we waddr=5, total 7 cycles.
REQ-022 beq with alu_zero=1 -> pc_we, pc_sel=1 in EXEC; alu_zero=0 -> pc_sel=0; no reg_we either case.
REQ-023 opcode 111111 -> illegal pulse one cycle, no reg_we/mem_*; next instr accepted 2 cycles after.
REQ-024 movz $2,$1,$3 with macro, b_zero=0 -> no reg_we; b_zero=1 -> reg_we waddr=2; without macro -> illegal.
REQ-025 rst_n low during MEM of sw -> mem_we drops immediately, state=0, instr_ready=1 after release.
